// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares main memory between I/D cache block fills and write-through stores
module mem_arbiter #(
  parameter int AWIDTH      = 16,
  parameter int DWIDTH      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int WORD_BYTES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_valid,
  output logic              i_done,
  input  logic              d_req,
  input  logic [AWIDTH-1:0] d_addr,
  output logic              d_grant,
  output logic              d_data_valid,
  output logic              d_done,
  input  logic              st_req,
  input  logic [AWIDTH-1:0] st_addr,
  input  logic [DWIDTH-1:0] st_data,
  output logic              st_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data_in,
  input  logic [DWIDTH-1:0] mem_data_out,
  input  logic              mem_data_valid,
  output logic [DWIDTH-1:0] fill_data,
  output logic              busy
);

  localparam int CW = $clog2(BLOCK_WORDS + 1);
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, FILL = 2'd2} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_issue_cnt;
  logic [CW-1:0]     r_recv_cnt;
  logic              r_owner;
  logic              r_last_fill;
  logic [AWIDTH-1:0] r_base;
  logic [AWIDTH-1:0] r_mem_addr;
  logic [DWIDTH-1:0] r_mem_data_in;
  logic              r_mem_en;
  logic              r_mem_wr;
  logic              r_st_ack;
  logic              r_i_grant;
  logic              r_d_grant;
  logic              r_i_done;
  logic              r_d_done;

  logic              w_pick_d;
  logic [AWIDTH-1:0] w_addr_sel;
  logic [AWIDTH-1:0] w_base_sel;
  logic [AWIDTH-1:0] w_next_addr;
  logic              w_fill_valid;
  logic              w_last_word;

  // Round-robin only matters when both fill sides are requesting.
  assign w_pick_d     = (d_req && !i_req) || (i_req && d_req && (r_last_fill == SIDE_I));
  assign w_addr_sel   = w_pick_d ? d_addr : i_addr;
  assign w_base_sel   = w_addr_sel & ~{{(AWIDTH-4){1'b0}}, 4'hF};
  assign w_next_addr  = r_base + AWIDTH'((32'(r_issue_cnt) + 32'd1) * WORD_BYTES);
  assign w_fill_valid = (r_state == FILL) && mem_data_valid;
  assign w_last_word  = w_fill_valid && (r_recv_cnt == CW'(BLOCK_WORDS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_issue_cnt   <= '0;
      r_recv_cnt    <= '0;
      r_owner       <= SIDE_I;
      r_last_fill   <= SIDE_D;
      r_base        <= '0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
      r_mem_en      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_st_ack      <= 1'b0;
      r_i_grant     <= 1'b0;
      r_d_grant     <= 1'b0;
      r_i_done      <= 1'b0;
      r_d_done      <= 1'b0;
    end else begin
      r_st_ack <= 1'b0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // The done cycle is spent idle so nothing is regranted back-to-back.
          if (r_i_done || r_d_done) begin
            r_state <= IDLE;
          end else if (st_req) begin
            r_state       <= WRITE;
            r_mem_en      <= 1'b1;
            r_mem_wr      <= 1'b1;
            r_mem_addr    <= st_addr;
            r_mem_data_in <= st_data;
            r_st_ack      <= 1'b1;
          end else if (i_req || d_req) begin
            r_state       <= FILL;
            r_owner       <= w_pick_d;
            r_base        <= w_base_sel;
            r_mem_addr    <= w_base_sel;
            r_mem_en      <= 1'b1;
            r_mem_wr      <= 1'b0;
            r_mem_data_in <= '0;
            r_issue_cnt   <= '0;
            r_recv_cnt    <= '0;
            r_i_grant     <= !w_pick_d;
            r_d_grant     <= w_pick_d;
          end
        end
        WRITE: begin
          r_state       <= IDLE;
          r_mem_en      <= 1'b0;
          r_mem_wr      <= 1'b0;
          r_mem_addr    <= '0;
          r_mem_data_in <= '0;
        end
        FILL: begin
          if (r_issue_cnt < CW'(BLOCK_WORDS)) r_issue_cnt <= r_issue_cnt + 1'b1;
          if (r_issue_cnt < CW'(BLOCK_WORDS - 1)) r_mem_addr <= w_next_addr;
          if (w_fill_valid) r_recv_cnt <= r_recv_cnt + 1'b1;
          if (w_last_word) begin
            r_state     <= IDLE;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_i_grant   <= 1'b0;
            r_d_grant   <= 1'b0;
            r_last_fill <= r_owner;
            r_i_done    <= (r_owner == SIDE_I);
            r_d_done    <= (r_owner == SIDE_D);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_grant      = r_i_grant;
  assign d_grant      = r_d_grant;
  assign i_done       = r_i_done;
  assign d_done       = r_d_done;
  assign st_ack       = r_st_ack;
  assign mem_en       = r_mem_en;
  assign mem_wr       = r_mem_wr;
  assign mem_addr     = r_mem_addr;
  assign mem_data_in  = r_mem_data_in;
  assign i_data_valid = w_fill_valid && (r_owner == SIDE_I);
  assign d_data_valid = w_fill_valid && (r_owner == SIDE_D);
  assign fill_data    = mem_data_out;
  assign busy         = (r_state != IDLE);

endmodule
